// File: rtl/lcd_cmd_sequencer.sv
// lcd_cmd_sequencer: 8080-bus TFT driver playing the panel init script or a single-cell colour fill; LCD_RST_PIN_EN adds lcd_rst_n.
// Latency: first write strobe one cycle after the request edge, 2 cycles per byte, cmd_done one cycle after the last byte.
// No backpressure: requests are level-held; dropping the active one ends the sequence after the current byte.
module lcd_cmd_sequencer #(
  parameter int CELL_PX   = 8,
  parameter int RESET_DLY = 150000,
  parameter int SLEEP_DLY = 1200000,
  parameter int HWRST_DLY = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_cycle,
  input  logic        en_update,
  input  logic [7:0]  cell_x,
  input  logic [7:0]  cell_y,
  input  logic [15:0] cell_color,
  output logic        cmd_done,
  output logic        busy,
  output logic        lcd_cs_n,
  output logic        lcd_wr_n,
  output logic        lcd_dc,
  output logic [7:0]  lcd_data
`ifdef LCD_RST_PIN_EN
  ,
  output logic        lcd_rst_n
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    INIT_BYTE,
    INIT_DELAY,
    UPD_BYTE,
    UPD_PIXEL,
    DONE
  } state_t;

  // Delay stages inside INIT_DELAY
  localparam logic [1:0] ST_HW_LO  = 2'd0;
  localparam logic [1:0] ST_HW_REC = 2'd1;
  localparam logic [1:0] ST_RESET  = 2'd2;
  localparam logic [1:0] ST_SLEEP  = 2'd3;

  localparam logic [3:0] INIT_LAST = 4'd6;
  localparam logic [3:0] UPD_LAST  = 4'd10;
  localparam logic [8:0] PIX_LAST  = 9'(CELL_PX * CELL_PX - 1);

  state_t      state, state_nx;
  logic [3:0]  idx, idx_nx;
  logic        phase, phase_nx;
  logic [1:0]  stage, stage_nx;
  logic [31:0] dly_cnt, dly_cnt_nx;
  logic [31:0] dly_end;
  logic [8:0]  pix, pix_nx;
  logic        pbyte, pbyte_nx;
  logic        abort, abort_nx;
  logic        req_act;
  logic [7:0]  lat_x, lat_y;
  logic [15:0] lat_color;
  logic [15:0] x0, x1, y0, y1;
  logic [8:0]  init_dat, upd_dat;

  assign x0 = 16'(lat_x) * 16'(CELL_PX);
  assign y0 = 16'(lat_y) * 16'(CELL_PX);
  assign x1 = x0 + 16'(CELL_PX - 1);
  assign y1 = y0 + 16'(CELL_PX - 1);

  assign req_act = (state == INIT_BYTE || state == INIT_DELAY) ? init_cycle : en_update;

  always_comb begin
    dly_end = 32'(SLEEP_DLY - 1);
    case (stage)
      ST_HW_LO, ST_HW_REC: dly_end = 32'(HWRST_DLY - 1);
      ST_RESET:            dly_end = 32'(RESET_DLY - 1);
      default:             dly_end = 32'(SLEEP_DLY - 1);
    endcase
  end

  // {dc, data} of the init script
  always_comb begin
    init_dat = 9'h029;
    case (idx)
      4'd0:    init_dat = 9'h001;
      4'd1:    init_dat = 9'h011;
      4'd2:    init_dat = 9'h03A;
      4'd3:    init_dat = 9'h155;
      4'd4:    init_dat = 9'h036;
      4'd5:    init_dat = 9'h108;
      default: init_dat = 9'h029;
    endcase
  end

  // {dc, data} of the address-window header
  always_comb begin
    upd_dat = 9'h02C;
    case (idx)
      4'd0:    upd_dat = 9'h02A;
      4'd1:    upd_dat = {1'b1, x0[15:8]};
      4'd2:    upd_dat = {1'b1, x0[7:0]};
      4'd3:    upd_dat = {1'b1, x1[15:8]};
      4'd4:    upd_dat = {1'b1, x1[7:0]};
      4'd5:    upd_dat = 9'h02B;
      4'd6:    upd_dat = {1'b1, y0[15:8]};
      4'd7:    upd_dat = {1'b1, y0[7:0]};
      4'd8:    upd_dat = {1'b1, y1[15:8]};
      4'd9:    upd_dat = {1'b1, y1[7:0]};
      default: upd_dat = 9'h02C;
    endcase
  end

  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    phase_nx   = phase;
    stage_nx   = stage;
    dly_cnt_nx = dly_cnt;
    pix_nx     = pix;
    pbyte_nx   = pbyte;
    abort_nx   = abort;
    case (state)
      IDLE: begin
        idx_nx     = '0;
        phase_nx   = 1'b0;
        pix_nx     = '0;
        pbyte_nx   = 1'b0;
        abort_nx   = 1'b0;
        dly_cnt_nx = '0;
        if (init_cycle) begin
`ifdef LCD_RST_PIN_EN
          state_nx = INIT_DELAY;
          stage_nx = ST_HW_LO;
`else
          state_nx = INIT_BYTE;
`endif
        end else if (en_update) begin
          state_nx = UPD_BYTE;
        end
      end
      INIT_BYTE, UPD_BYTE, UPD_PIXEL: begin
        if (!phase) begin
          // A drop seen during phase L still lets phase H complete
          phase_nx = 1'b1;
          abort_nx = !req_act;
        end else begin
          phase_nx = 1'b0;
          if (abort || !req_act) begin
            state_nx = IDLE;
          end else if (state == INIT_BYTE) begin
            if (idx == 4'd0) begin
              state_nx   = INIT_DELAY;
              stage_nx   = ST_RESET;
              dly_cnt_nx = '0;
            end else if (idx == 4'd1) begin
              state_nx   = INIT_DELAY;
              stage_nx   = ST_SLEEP;
              dly_cnt_nx = '0;
            end else if (idx == INIT_LAST) begin
              state_nx = DONE;
            end else begin
              idx_nx = idx + 4'd1;
            end
          end else if (state == UPD_BYTE) begin
            if (idx == UPD_LAST) state_nx = UPD_PIXEL;
            else                 idx_nx   = idx + 4'd1;
          end else begin
            pbyte_nx = !pbyte;
            if (pbyte) begin
              if (pix == PIX_LAST) state_nx = DONE;
              else                 pix_nx   = pix + 9'd1;
            end
          end
        end
      end
      INIT_DELAY: begin
        dly_cnt_nx = dly_cnt + 32'd1;
        if (!init_cycle) begin
          state_nx = IDLE;
        end else if (dly_cnt == dly_end) begin
          dly_cnt_nx = '0;
          case (stage)
            ST_HW_LO:  stage_nx = ST_HW_REC;
            ST_HW_REC: state_nx = INIT_BYTE;
            ST_RESET: begin
              state_nx = INIT_BYTE;
              idx_nx   = 4'd1;
            end
            default: begin
              state_nx = INIT_BYTE;
              idx_nx   = 4'd2;
            end
          endcase
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      phase   <= 1'b0;
      stage   <= ST_RESET;
      dly_cnt <= '0;
      pix     <= '0;
      pbyte   <= 1'b0;
      abort   <= 1'b0;
    end else begin
      state   <= state_nx;
      idx     <= idx_nx;
      phase   <= phase_nx;
      stage   <= stage_nx;
      dly_cnt <= dly_cnt_nx;
      pix     <= pix_nx;
      pbyte   <= pbyte_nx;
      abort   <= abort_nx;
    end
  end

  // Cell geometry and colour are frozen at the start edge
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      lat_x     <= cell_x;
      lat_y     <= cell_y;
      lat_color <= cell_color;
    end
  end

  always_comb begin
    cmd_done = (state == DONE);
    busy     = 1'b0;
    lcd_cs_n = 1'b1;
    lcd_wr_n = 1'b1;
    lcd_dc   = 1'b1;
    lcd_data = '0;
    case (state)
      INIT_BYTE, INIT_DELAY: begin
        busy     = 1'b1;
        lcd_cs_n = 1'b0;
        lcd_wr_n = (state == INIT_DELAY) || phase;
        // The hardware-reset stages precede any byte, so the bus stays at rest
        if (!(state == INIT_DELAY && !stage[1])) begin
          {lcd_dc, lcd_data} = init_dat;
        end
      end
      UPD_BYTE: begin
        busy               = 1'b1;
        lcd_cs_n           = 1'b0;
        lcd_wr_n           = phase;
        {lcd_dc, lcd_data} = upd_dat;
      end
      UPD_PIXEL: begin
        busy     = 1'b1;
        lcd_cs_n = 1'b0;
        lcd_wr_n = phase;
        lcd_dc   = 1'b1;
        lcd_data = pbyte ? lat_color[7:0] : lat_color[15:8];
      end
      default: ;
    endcase
  end

`ifdef LCD_RST_PIN_EN
  assign lcd_rst_n = !(state == INIT_DELAY && stage == ST_HW_LO);
`endif

endmodule
